// File: rtl/normal_eq_accumulator.sv
// -----------------------------------------------------------------------------
// normal_eq_accumulator
//
// Purpose:
//   Front end of the 3x3 least-squares solver used in the Longstaff-Schwartz
//   backward-induction loop. For one exercise date it streams per-path samples
//   (spot S, discounted continuation cashflow Y, in-the-money flag) and builds
//   the normal equations of the basis {1, S, S^2} over in-the-money paths only.
//   When the batch ends, the matrix A (3x3, row-major) and the right-hand side
//   B (3x1) are published to the solver. They stay stable until the solver
//   reports completion.
//
// Ports:
//   clk             clock
//   rst             asynchronous reset, active high
//   in_valid        sample valid
//   in_ready        sample accepted (handshake = in_valid & in_ready)
//   in_itm          path in the money (0 = sample consumed, not accumulated)
//   in_s            spot price, signed Q(WIDTH-FRAC).FRAC
//   in_y            discounted cashflow, signed Q(WIDTH-FRAC).FRAC
//   in_last         last sample of the batch
//   A_flat[0:8]     normal matrix, A[i][j] = A_flat[3i+j]
//   B_flat[0:2]     right-hand side
//   out_valid       A/B valid and stable
//   solve_start     one-cycle start pulse to the solver
//   solver_done     solver finished; releases A/B
//   itm_count       number of ITM samples in the published batch
//   underdetermined itm_count < 3 (meaningful while out_valid)
//   sat_flag        sticky per batch: some product/accumulator/output saturated
// -----------------------------------------------------------------------------
module normal_eq_accumulator #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_itm,
    input  logic signed [WIDTH-1:0] in_s,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic                    in_last,
    output logic signed [WIDTH-1:0] A_flat [0:8],
    output logic signed [WIDTH-1:0] B_flat [0:2],
    output logic                    out_valid,
    output logic                    solve_start,
    input  logic                    solver_done,
    output logic [CNT_W-1:0]        itm_count,
    output logic                    underdetermined,
    output logic                    sat_flag
);

    localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] A_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    // 1.0 in fixed point: the sample count is accumulated already scaled by 2^FRAC
    localparam logic signed [WIDTH-1:0] ONE_Q = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    // Fixed-point multiply: full-width product, floor shift by FRAC, clamp to WIDTH.
    // Returns {overflow, value}.
    function automatic logic [WIDTH:0] mul_sat(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] prod;
        logic signed [2*WIDTH-1:0] shifted;
        prod    = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        shifted = prod >>> FRAC;
        if (shifted[2*WIDTH-1:WIDTH-1] == '0 || shifted[2*WIDTH-1:WIDTH-1] == '1)
            return {1'b0, shifted[WIDTH-1:0]};
        else if (shifted[2*WIDTH-1])
            return {1'b1, W_MIN};
        else
            return {1'b1, W_MAX};
    endfunction

    // Accumulator add that clamps at the ACC_W signed bounds. Returns {overflow, sum}.
    function automatic logic [ACC_W:0] acc_sat_add(input logic signed [ACC_W-1:0] acc,
                                                   input logic signed [WIDTH-1:0] addend);
        logic [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-WIDTH){addend[WIDTH-1]}}, addend};
        if (sum[ACC_W] == sum[ACC_W-1])
            return {1'b0, sum[ACC_W-1:0]};
        else if (sum[ACC_W])
            return {1'b1, A_MIN};
        else
            return {1'b1, A_MAX};
    endfunction

    // Narrow an accumulator to the output word width with clamping. Returns {overflow, value}.
    function automatic logic [WIDTH:0] narrow_sat(input logic signed [ACC_W-1:0] v);
        if (v[ACC_W-1:WIDTH-1] == '0 || v[ACC_W-1:WIDTH-1] == '1)
            return {1'b0, v[WIDTH-1:0]};
        else if (v[ACC_W-1])
            return {1'b1, W_MIN};
        else
            return {1'b1, W_MAX};
    endfunction

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] drain_cnt;
    logic       handshake;
    logic       publish;
    logic       release_batch;

    // Stage registers of the product pipeline
    logic                    st1_valid, st1_itm;
    logic signed [WIDTH-1:0] st1_s, st1_y;
    logic                    st2_valid, st2_itm, st2_sat;
    logic signed [WIDTH-1:0] st2_s, st2_y, st2_s2;
    logic                    st3_valid, st3_itm, st3_sat;
    logic signed [WIDTH-1:0] st3_s, st3_y, st3_s2, st3_s3, st3_s4, st3_sy, st3_s2y;

    logic                    s2_ovf, s3_ovf, s4_ovf, sy_ovf, s2y_ovf;
    logic signed [WIDTH-1:0] s2_prod, s3_prod, s4_prod, sy_prod, s2y_prod;

    // Accumulator order: n, S, S^2, S^3, S^4, Y, SY, S^2Y
    logic signed [ACC_W-1:0] acc_q   [0:7];
    logic signed [ACC_W-1:0] acc_sum [0:7];
    logic signed [ACC_W-1:0] acc_upd [0:7];
    logic signed [WIDTH-1:0] addend  [0:7];
    logic signed [WIDTH-1:0] nar_val [0:7];
    logic [7:0]              acc_ovf;
    logic [7:0]              nar_ovf;
    logic                    accumulate;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_upd;
    logic             cnt_ovf;

    // Batch control: accept samples, let the pipeline drain for three cycles so
    // the last sample lands in the accumulators, then hold results for the solver.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == 2'd2)
                    state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (solver_done)
                    state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    assign handshake     = in_valid & in_ready;
    assign publish       = (state_q == ST_DRAIN) && (drain_cnt == 2'd2);
    assign release_batch = (state_q == ST_HOLD) && solver_done;

    // State register plus the drain cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            drain_cnt <= 2'd0;
        end else begin
            state_q   <= state_d;
            drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Stage 1 captures the accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st1_valid <= 1'b0;
            st1_itm   <= 1'b0;
            st1_s     <= '0;
            st1_y     <= '0;
        end else begin
            st1_valid <= handshake;
            if (handshake) begin
                st1_itm <= in_itm;
                st1_s   <= in_s;
                st1_y   <= in_y;
            end
        end
    end

    assign {s2_ovf, s2_prod} = mul_sat(st1_s, st1_s);

    // Stage 2 forms S^2; saturation only matters for paths that will be accumulated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st2_valid <= 1'b0;
            st2_itm   <= 1'b0;
            st2_sat   <= 1'b0;
            st2_s     <= '0;
            st2_y     <= '0;
            st2_s2    <= '0;
        end else begin
            st2_valid <= st1_valid;
            st2_itm   <= st1_itm;
            st2_sat   <= st1_valid & st1_itm & s2_ovf;
            st2_s     <= st1_s;
            st2_y     <= st1_y;
            st2_s2    <= s2_prod;
        end
    end

    assign {s3_ovf,  s3_prod}  = mul_sat(st2_s2, st2_s);
    assign {s4_ovf,  s4_prod}  = mul_sat(st2_s2, st2_s2);
    assign {sy_ovf,  sy_prod}  = mul_sat(st2_s,  st2_y);
    assign {s2y_ovf, s2y_prod} = mul_sat(st2_s2, st2_y);

    // Stage 3 forms the remaining higher-order products in parallel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st3_valid <= 1'b0;
            st3_itm   <= 1'b0;
            st3_sat   <= 1'b0;
            st3_s     <= '0;
            st3_y     <= '0;
            st3_s2    <= '0;
            st3_s3    <= '0;
            st3_s4    <= '0;
            st3_sy    <= '0;
            st3_s2y   <= '0;
        end else begin
            st3_valid <= st2_valid;
            st3_itm   <= st2_itm;
            st3_sat   <= st2_sat |
                         (st2_valid & st2_itm & (s3_ovf | s4_ovf | sy_ovf | s2y_ovf));
            st3_s     <= st2_s;
            st3_y     <= st2_y;
            st3_s2    <= st2_s2;
            st3_s3    <= s3_prod;
            st3_s4    <= s4_prod;
            st3_sy    <= sy_prod;
            st3_s2y   <= s2y_prod;
        end
    end

    assign accumulate = st3_valid & st3_itm;

    assign addend[0] = ONE_Q;
    assign addend[1] = st3_s;
    assign addend[2] = st3_s2;
    assign addend[3] = st3_s3;
    assign addend[4] = st3_s4;
    assign addend[5] = st3_y;
    assign addend[6] = st3_sy;
    assign addend[7] = st3_s2y;

    // Next accumulator values; the publish path reads these so the final
    // sample is included on the same edge that it is accumulated.
    always_comb begin
        acc_ovf = '0;
        nar_ovf = '0;
        for (int i = 0; i < 8; i++) begin
            {acc_ovf[i], acc_sum[i]} = acc_sat_add(acc_q[i], addend[i]);
            acc_upd[i] = accumulate ? acc_sum[i] : acc_q[i];
            {nar_ovf[i], nar_val[i]} = narrow_sat(acc_upd[i]);
        end
    end

    // ITM sample counter sticks at its maximum instead of wrapping
    always_comb begin
        cnt_ovf = 1'b0;
        cnt_upd = cnt_q;
        if (accumulate) begin
            if (&cnt_q)
                cnt_ovf = 1'b1;
            else
                cnt_upd = cnt_q + 1'b1;
        end
    end

    // Running sums, cleared once the solver has consumed the batch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                acc_q[i] <= '0;
            cnt_q <= '0;
        end else if (release_batch) begin
            for (int i = 0; i < 8; i++)
                acc_q[i] <= '0;
            cnt_q <= '0;
        end else if (accumulate) begin
            for (int i = 0; i < 8; i++)
                acc_q[i] <= acc_upd[i];
            cnt_q <= cnt_upd;
        end
    end

    // Sticky saturation indicator for the current batch
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_flag <= 1'b0;
        else if (release_batch)
            sat_flag <= 1'b0;
        else if ((accumulate && (st3_sat || (|acc_ovf) || cnt_ovf)) ||
                 (publish && (|nar_ovf)))
            sat_flag <= 1'b1;
    end

    // Published results: loaded when draining completes, kept after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++)
                A_flat[i] <= '0;
            for (int i = 0; i < 3; i++)
                B_flat[i] <= '0;
            itm_count       <= '0;
            underdetermined <= 1'b0;
            out_valid       <= 1'b0;
            solve_start     <= 1'b0;
        end else begin
            solve_start <= publish;
            if (publish) begin
                A_flat[0]       <= nar_val[0];
                A_flat[1]       <= nar_val[1];
                A_flat[2]       <= nar_val[2];
                A_flat[3]       <= nar_val[1];
                A_flat[4]       <= nar_val[2];
                A_flat[5]       <= nar_val[3];
                A_flat[6]       <= nar_val[2];
                A_flat[7]       <= nar_val[3];
                A_flat[8]       <= nar_val[4];
                B_flat[0]       <= nar_val[5];
                B_flat[1]       <= nar_val[6];
                B_flat[2]       <= nar_val[7];
                itm_count       <= cnt_upd;
                underdetermined <= (cnt_upd < CNT_W'(3));
                out_valid       <= 1'b1;
            end else if (release_batch) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_normal_eq_accumulator.sv
// -----------------------------------------------------------------------------
// tb_normal_eq_accumulator
//
// Directed bench for normal_eq_accumulator. Each accepted sample feeds a small
// arithmetic model; the end of a batch pushes the expected publication onto a
// scoreboard queue, which is popped when the solver start pulse appears.
// -----------------------------------------------------------------------------
module tb_normal_eq_accumulator;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;
    localparam int ACC_W = 48;
    localparam int CNT_W = 16;

    localparam longint W_MAX = (longint'(1) << 31) - 1;
    localparam longint W_MIN = -(longint'(1) << 31);
    localparam longint A_MAX = (longint'(1) << 47) - 1;
    localparam longint A_MIN = -(longint'(1) << 47);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_itm;
    logic signed [WIDTH-1:0] in_s;
    logic signed [WIDTH-1:0] in_y;
    logic                    in_last;
    logic signed [WIDTH-1:0] A_flat [0:8];
    logic signed [WIDTH-1:0] B_flat [0:2];
    logic                    out_valid;
    logic                    solve_start;
    logic                    solver_done;
    logic [CNT_W-1:0]        itm_count;
    logic                    underdetermined;
    logic                    sat_flag;

    typedef struct packed {
        logic [8:0][31:0] a;
        logic [2:0][31:0] b;
        logic [15:0]      cnt;
        logic             under;
        logic             sat;
    } exp_t;

    exp_t   exp_q [$];
    longint m_acc [8];
    int     m_cnt;
    bit     m_sat;
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     cyc          = 0;
    int     last_hs_cyc  = 0;

    normal_eq_accumulator #(
        .WIDTH(WIDTH),
        .FRAC (FRAC),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_itm         (in_itm),
        .in_s           (in_s),
        .in_y           (in_y),
        .in_last        (in_last),
        .A_flat         (A_flat),
        .B_flat         (B_flat),
        .out_valid      (out_valid),
        .solve_start    (solve_start),
        .solver_done    (solver_done),
        .itm_count      (itm_count),
        .underdetermined(underdetermined),
        .sat_flag       (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic reportTimeout(input string tag);
        tests_run++;
        tests_failed++;
        $error("[TB] FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi,
                                     output bit hit);
        hit = 1'b0;
        if (v > hi) begin
            hit = 1'b1;
            return hi;
        end
        if (v < lo) begin
            hit = 1'b1;
            return lo;
        end
        return v;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 8; i++)
            m_acc[i] = 0;
        m_cnt = 0;
        m_sat = 1'b0;
    endtask

    task automatic modelSample(input int s, input int y, input bit itm);
        longint ls, ly, s2, s3, s4, sy, s2y;
        longint add [8];
        bit     h;
        if (!itm)
            return;
        ls  = s;
        ly  = y;
        s2  = clamp((ls * ls) >>> FRAC, W_MIN, W_MAX, h);  m_sat |= h;
        s3  = clamp((s2 * ls) >>> FRAC, W_MIN, W_MAX, h);  m_sat |= h;
        s4  = clamp((s2 * s2) >>> FRAC, W_MIN, W_MAX, h);  m_sat |= h;
        sy  = clamp((ls * ly) >>> FRAC, W_MIN, W_MAX, h);  m_sat |= h;
        s2y = clamp((s2 * ly) >>> FRAC, W_MIN, W_MAX, h);  m_sat |= h;
        add[0] = 65536;
        add[1] = ls;
        add[2] = s2;
        add[3] = s3;
        add[4] = s4;
        add[5] = ly;
        add[6] = sy;
        add[7] = s2y;
        for (int k = 0; k < 8; k++) begin
            m_acc[k] = clamp(m_acc[k] + add[k], A_MIN, A_MAX, h);
            m_sat |= h;
        end
        if (m_cnt == 65535)
            m_sat = 1'b1;
        else
            m_cnt++;
    endtask

    task automatic pushExpected();
        exp_t   e;
        longint v [8];
        bit     h;
        for (int k = 0; k < 8; k++) begin
            v[k] = clamp(m_acc[k], W_MIN, W_MAX, h);
            m_sat |= h;
        end
        e.a[0]  = 32'(v[0]);
        e.a[1]  = 32'(v[1]);
        e.a[2]  = 32'(v[2]);
        e.a[3]  = 32'(v[1]);
        e.a[4]  = 32'(v[2]);
        e.a[5]  = 32'(v[3]);
        e.a[6]  = 32'(v[2]);
        e.a[7]  = 32'(v[3]);
        e.a[8]  = 32'(v[4]);
        e.b[0]  = 32'(v[5]);
        e.b[1]  = 32'(v[6]);
        e.b[2]  = 32'(v[7]);
        e.cnt   = 16'(m_cnt);
        e.under = (m_cnt < 3);
        e.sat   = m_sat;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake
    task automatic applyStimulus(input int s, input int y, input bit itm, input bit last);
        int waited = 0;
        in_valid = 1'b1;
        in_s     = s;
        in_y     = y;
        in_itm   = itm;
        in_last  = last;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            reportTimeout("in_ready");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        modelSample(s, y, itm);
        if (last)
            pushExpected();
        @(negedge clk);
        last_hs_cyc = cyc;
        in_valid    = 1'b0;
        in_last     = 1'b0;
    endtask

    // Waits for the start pulse, then compares the publication with the scoreboard
    task automatic checkOutput(input string tag);
        int   waited = 0;
        exp_t e;
        while (solve_start !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (solve_start !== 1'b1) begin
            reportTimeout({tag, "_solve_start"});
            return;
        end
        checkValue({tag, "_latency"}, 32'(cyc - last_hs_cyc), 32'd3);
        if (exp_q.size() == 0) begin
            reportTimeout({tag, "_scoreboard"});
            return;
        end
        e = exp_q.pop_front();
        checkValue({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        for (int i = 0; i < 9; i++)
            checkValue($sformatf("%s_A%0d", tag, i), A_flat[i], e.a[i]);
        for (int i = 0; i < 3; i++)
            checkValue($sformatf("%s_B%0d", tag, i), B_flat[i], e.b[i]);
        checkValue({tag, "_itm_count"}, 32'(itm_count), 32'(e.cnt));
        checkValue({tag, "_underdet"}, 32'(underdetermined), 32'(e.under));
        checkValue({tag, "_sat_flag"}, 32'(sat_flag), 32'(e.sat));
        @(negedge clk);
        checkValue({tag, "_pulse_end"}, 32'(solve_start), 32'd0);
        checkValue({tag, "_still_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic pulseSolverDone();
        solver_done = 1'b1;
        @(negedge clk);
        solver_done = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 9; i++)
            checkValue($sformatf("%s_A%0d", tag, i), A_flat[i], 32'd0);
        for (int i = 0; i < 3; i++)
            checkValue($sformatf("%s_B%0d", tag, i), B_flat[i], 32'd0);
        checkValue({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        checkValue({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkValue({tag, "_solve_start"}, 32'(solve_start), 32'd0);
        checkValue({tag, "_itm_count"}, 32'(itm_count), 32'd0);
        checkValue({tag, "_underdet"}, 32'(underdetermined), 32'd0);
        checkValue({tag, "_sat_flag"}, 32'(sat_flag), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_itm      = 1'b0;
        in_s        = '0;
        in_y        = '0;
        in_last     = 1'b0;
        solver_done = 1'b0;
        modelClear();

        // Reset state
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Three ITM samples 1.0, 2.0, 3.0
        applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        applyStimulus(32'h0002_0000, 32'h0002_0000, 1'b1, 1'b0);
        applyStimulus(32'h0003_0000, 32'h0003_0000, 1'b1, 1'b1);
        checkOutput("t1");

        // Upstream presents the next batch while results are held
        in_valid = 1'b1;
        in_s     = 32'h0002_0000;
        in_y     = 32'h0001_0000;
        in_itm   = 1'b1;
        in_last  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkValue("hold_in_ready", 32'(in_ready), 32'd0);
            checkValue("hold_out_valid", 32'(out_valid), 32'd1);
            checkValue("hold_A8", A_flat[8], 32'h0062_0000);
        end
        pulseSolverDone();
        checkValue("release_out_valid", 32'(out_valid), 32'd0);
        checkValue("release_in_ready", 32'(in_ready), 32'd1);
        checkValue("release_A0_kept", A_flat[0], 32'h0003_0000);
        checkValue("release_count_kept", 32'(itm_count), 32'd3);
        modelClear();
        applyStimulus(32'h0002_0000, 32'h0001_0000, 1'b1, 1'b1);
        checkOutput("t2");
        pulseSolverDone();
        modelClear();

        // Non-ITM samples with a huge spot interleaved: must not contribute
        applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        applyStimulus(32'h7FFF_0000, 32'h0001_0000, 1'b0, 1'b0);
        applyStimulus(32'h0002_0000, 32'h0002_0000, 1'b1, 1'b0);
        applyStimulus(32'h7FFF_0000, 32'h0001_0000, 1'b0, 1'b0);
        applyStimulus(32'h0003_0000, 32'h0003_0000, 1'b1, 1'b1);
        checkOutput("t3");
        pulseSolverDone();
        modelClear();

        // Saturating products
        applyStimulus(32'h7FFF_0000, 32'h0001_0000, 1'b1, 1'b1);
        checkOutput("t4");
        pulseSolverDone();
        modelClear();
        checkValue("t4_sat_cleared", 32'(sat_flag), 32'd0);

        // Reset in the middle of a batch
        applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        applyStimulus(32'h0002_0000, 32'h0002_0000, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        @(negedge clk);
        rst = 1'b0;
        modelClear();
        repeat (6) @(negedge clk);
        checkValue("midrst_no_publish", 32'(out_valid), 32'd0);
        checkValue("midrst_no_start", 32'(solve_start), 32'd0);

        // Same batch as the first, with a stray solver_done during accumulation
        applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        pulseSolverDone();
        applyStimulus(32'h0002_0000, 32'h0002_0000, 1'b1, 1'b0);
        applyStimulus(32'h0003_0000, 32'h0003_0000, 1'b1, 1'b1);
        checkOutput("t6");
        pulseSolverDone();
        modelClear();

        // Empty batch: single non-ITM sample marked last
        applyStimulus(32'h0003_0000, 32'h0001_0000, 1'b0, 1'b1);
        checkOutput("t7");
        pulseSolverDone();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
